// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY definitions: the pad symbol, the K-flag encoding, the link-width codes
// and the lane striper state type.
package pcie_phy_pkg;

  localparam logic [7:0] PAD_SYMBOL = 8'hF7;  // K23.7

  localparam logic K_DATA = 1'b0;
  localparam logic K_CTRL = 1'b1;

  typedef enum logic [2:0] {
    LW_X1  = 3'd0,
    LW_X2  = 3'd1,
    LW_X4  = 3'd2,
    LW_X8  = 3'd3,
    LW_X16 = 3'd4
  } link_width_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } striper_state_e;

  // Index of the last active lane for a width code, clamped to the widest supported code.
  function automatic int unsigned lw_last_slot(input int unsigned code,
                                               input int unsigned max_code);
    int unsigned c;
    c = (code > max_code) ? max_code : code;
    return (32'd1 << c) - 32'd1;
  endfunction

endpackage

// File: rtl/lane_striper.sv
// Distributes a byte stream across the negotiated number of lanes, padding the final
// partial stripe of each packet with PAD control symbols.
module lane_striper
  import pcie_phy_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned LOG2_LANES = $clog2(NUM_LANES),
  localparam int unsigned LW         = (LOG2_LANES > 0) ? LOG2_LANES : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [LW-1:0]                         link_width_i,
  input  logic [DATA_WIDTH-1:0]                 data_frame_i,
  input  logic                                  data_frame_valid_i,
  input  logic                                  data_frame_last_i,
  output logic                                  data_frame_ready_o,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  lane_data_o,
  output logic [NUM_LANES-1:0]                  lane_k_o,
  output logic [NUM_LANES-1:0]                  lane_valid_o,
  input  logic                                  lanes_ready_i,
  output logic                                  busy_o
);

  striper_state_e state_q, state_d;
  logic [LW-1:0] slot_q, slot_d;
  logic [LW-1:0] last_q, last_d;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] fill_q, fill_d;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_LANES-1:0] k_q, k_d;
  logic [NUM_LANES-1:0] valid_q, valid_d;

  logic          accept;
  logic          handoff;
  logic          complete;
  logic [LW-1:0] cur_slot;
  logic [LW-1:0] eff_last;

  assign data_frame_ready_o = ~(|valid_q) | lanes_ready_i;
  assign accept             = data_frame_valid_i & data_frame_ready_o;
  assign handoff            = (|valid_q) & lanes_ready_i;
  assign busy_o             = (state_q == ST_FILL) | (|valid_q);

  assign lane_data_o  = data_q;
  assign lane_k_o     = k_q;
  assign lane_valid_o = valid_q;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    last_d   = last_q;
    fill_d   = fill_q;
    data_d   = data_q;
    k_d      = k_q;
    valid_d  = valid_q;
    complete = 1'b0;

    // Width is only live in IDLE; once a stripe is open the registered width governs it.
    cur_slot = (state_q == ST_IDLE) ? '0 : slot_q;
    eff_last = (state_q == ST_IDLE) ? LW'(lw_last_slot(32'(link_width_i), LOG2_LANES))
                                    : last_q;

    if (handoff) begin
      data_d  = '0;
      k_d     = '0;
      valid_d = '0;
    end

    if (accept) begin
      fill_d[cur_slot] = data_frame_i;
      complete         = data_frame_last_i | (cur_slot == eff_last);
      if (state_q == ST_IDLE) begin
        last_d = eff_last;
      end
      if (complete) begin
        // A completing stripe overrides the handoff clear so stripes run back-to-back.
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
          if (i <= 32'(cur_slot)) begin
            data_d[i]  = fill_d[i];
            k_d[i]     = K_DATA;
            valid_d[i] = 1'b1;
          end else if (i <= 32'(eff_last)) begin
            data_d[i]  = DATA_WIDTH'(PAD_SYMBOL);
            k_d[i]     = K_CTRL;
            valid_d[i] = 1'b1;
          end else begin
            data_d[i]  = '0;
            k_d[i]     = K_DATA;
            valid_d[i] = 1'b0;
          end
        end
        state_d = ST_IDLE;
        slot_d  = '0;
      end else begin
        state_d = ST_FILL;
        slot_d  = cur_slot + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      last_q  <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      k_q     <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      last_q  <= last_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      k_q     <= k_d;
      valid_q <= valid_d;
    end
  end

endmodule
